// File: rtl/rc4_shuffle_engine.sv
// RC4 key-scheduling shuffle over a 256-byte S memory.
// The block is started by a one-cycle pulse and reports completion with a one-cycle finish pulse.
module rc4_shuffle_engine #(
  parameter int KEY_LENGTH = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [8*KEY_LENGTH-1:0] secret_key,
  output logic                    finish,
  output logic [7:0]              address,
  output logic [7:0]              data,
  output logic                    wren,
  input  logic [7:0]              q
);

  localparam int KW = (KEY_LENGTH > 1) ? $clog2(KEY_LENGTH) : 1;

  typedef enum logic [3:0] {
    IDLE, RD_I, WT_I, LD_I, RD_J, WT_J, LD_J, WR_I, WR_J, NEXT, DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [7:0]              i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d;
  logic [KW-1:0]           k_q, k_d;
  logic [8*KEY_LENGTH-1:0] key_q, key_d;
  logic                    finish_q, finish_d, wren_q, wren_d;
  logic [7:0]              addr_q, addr_d, data_q, data_d;

  // Byte 0 of the key is the most significant byte.
  function automatic logic [7:0] key_byte(input logic [8*KEY_LENGTH-1:0] key,
                                          input logic [KW-1:0] idx);
    key_byte = 8'h00;
    for (int b = 0; b < KEY_LENGTH; b++) begin
      if (idx == KW'(b)) key_byte = key[8*(KEY_LENGTH-1-b) +: 8];
    end
  endfunction

  // Next-state logic; outputs are decoded from the next state so they can be registered.
  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    j_d      = j_q;
    k_d      = k_q;
    si_d     = si_q;
    sj_d     = sj_q;
    key_d    = key_q;
    addr_d   = 8'h00;
    data_d   = 8'h00;
    wren_d   = 1'b0;
    finish_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          key_d   = secret_key;
          i_d     = 8'h00;
          j_d     = 8'h00;
          k_d     = '0;
          state_d = RD_I;
        end else begin
          state_d = IDLE;
        end
      end
      RD_I: state_d = WT_I;
      WT_I: state_d = LD_I;
      LD_I: begin
        si_d    = q;
        j_d     = j_q + q + key_byte(key_q, k_q);
        state_d = RD_J;
      end
      RD_J: state_d = WT_J;
      WT_J: state_d = LD_J;
      LD_J: begin
        sj_d    = q;
        state_d = WR_I;
      end
      WR_I: state_d = WR_J;
      WR_J: state_d = NEXT;
      NEXT: begin
        if (i_q == 8'hFF) begin
          state_d = DONE;
        end else begin
          i_d     = i_q + 8'd1;
          k_d     = (k_q == KW'(KEY_LENGTH-1)) ? '0 : k_q + KW'(1);
          state_d = RD_I;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    case (state_d)
      RD_I, WT_I: addr_d = i_d;
      RD_J, WT_J: addr_d = j_d;
      WR_I: begin
        addr_d = i_d;
        data_d = sj_d;
        wren_d = 1'b1;
      end
      WR_J: begin
        addr_d = j_d;
        data_d = si_d;
        wren_d = 1'b1;
      end
      DONE:    finish_d = 1'b1;
      default: addr_d = 8'h00;
    endcase
  end

  // State, datapath and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      i_q      <= 8'h00;
      j_q      <= 8'h00;
      k_q      <= '0;
      si_q     <= 8'h00;
      sj_q     <= 8'h00;
      key_q    <= '0;
      addr_q   <= 8'h00;
      data_q   <= 8'h00;
      wren_q   <= 1'b0;
      finish_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      j_q      <= j_d;
      k_q      <= k_d;
      si_q     <= si_d;
      sj_q     <= sj_d;
      key_q    <= key_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      wren_q   <= wren_d;
      finish_q <= finish_d;
    end
  end

  assign finish  = finish_q;
  assign address = addr_q;
  assign data    = data_q;
  assign wren    = wren_q;

endmodule

// File: tb/tb_rc4_shuffle_engine.sv
// Bench for rc4_shuffle_engine: RAM model, software KSA model feeding a write scoreboard,
// plus timing, abort, ignored-start and key-latch scenarios.
module tb_rc4_shuffle_engine;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [23:0] secret_key = 24'h000000;
  logic        finish, wren;
  logic [7:0]  address, data, q;

  logic [7:0]  ram [256];
  logic [7:0]  exp_mem [256];

  typedef struct {logic [7:0] a; logic [7:0] d;} wr_t;
  wr_t exp_q[$];

  int          pass_cnt = 0;
  int          chk_cnt = 0;
  int          nwr;
  int          wr_n [2];
  logic [7:0]  wr_a [2];
  logic [7:0]  wr_d [2];
  int          wren_first;
  logic [7:0]  snap2, snap3;

  rc4_shuffle_engine #(.KEY_LENGTH(3)) dut (
    .clk(clk), .reset(reset), .start(start), .secret_key(secret_key),
    .finish(finish), .address(address), .data(data), .wren(wren), .q(q)
  );

  always #5 clk = ~clk;

  // Single-port RAM: registered read, write at the edge ending a wren cycle.
  always @(posedge clk) begin
    if (wren) ram[address] <= data;
    q <= ram[address];
  end

  // Scoreboard: every observed write must match the next expected write.
  always @(negedge clk) begin
    if (wren) begin
      chk_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_write: got addr=%0h data=%0h, required no write", address, data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (address !== e.a || data !== e.d)
          $display("FAIL write: got addr=%0h data=%0h, required addr=%0h data=%0h",
                   address, data, e.a, e.d);
        else pass_cnt++;
      end
    end
  end

  task automatic fill_identity();
    for (int a = 0; a < 256; a++) begin
      ram[a]     = 8'(a);
      exp_mem[a] = 8'(a);
    end
  endtask

  // Software KSA on exp_mem, pushing the expected write sequence.
  task automatic model_ksa(input logic [23:0] key, input int n_iter);
    logic [7:0] j, si, sj, kb;
    logic [23:0] ks;
    j = 8'h00;
    for (int i = 0; i < n_iter; i++) begin
      ks = key >> (8 * (2 - (i % 3)));
      kb = ks[7:0];
      si = exp_mem[i];
      j  = j + si + kb;
      sj = exp_mem[j];
      exp_q.push_back('{a: 8'(i), d: sj});
      exp_q.push_back('{a: j, d: si});
      exp_mem[i] = sj;
      exp_mem[j] = si;
    end
  endtask

  task automatic drive_run(input logic [23:0] key, input logic [23:0] key2, input int chg_at,
                           input int p1, input int p2, input int abort_at,
                           output int fin_n, output int fin_cnt);
    fin_n = -1;
    fin_cnt = 0;
    nwr = 0;
    wren_first = 0;
    @(negedge clk);
    secret_key = key;
    start = 1'b1;
    @(posedge clk);
    for (int n = 0; n < 2400; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (finish) begin
        fin_cnt++;
        fin_n = n;
      end
      if (wren && n < 9) wren_first++;
      if (wren && nwr < 2) begin
        wr_n[nwr] = n;
        wr_a[nwr] = address;
        wr_d[nwr] = data;
        nwr++;
      end
      if (n == 27) begin
        snap2 = ram[2];
        snap3 = ram[3];
      end
      if (abort_at >= 0 && n == abort_at) begin
        reset = 1'b1;
        break;
      end
      if (fin_cnt > 0 && n >= p2) break;
      if (n + 1 == p1 || n + 1 == p2) start = 1'b1;
      if (n + 1 == chg_at) secret_key = key2;
      if (n + 1 == abort_at) reset = 1'b0;
    end
  endtask

  task automatic check_done(input string name, input int fin_n, input int fin_cnt);
    int bad;
    chk_cnt++;
    if (fin_n !== 2304) $display("FAIL %s_finish_time: got %0d, required 2304", name, fin_n);
    else pass_cnt++;
    chk_cnt++;
    if (fin_cnt !== 1) $display("FAIL %s_finish_count: got %0d, required 1", name, fin_cnt);
    else pass_cnt++;
    bad = 0;
    for (int a = 0; a < 256; a++) if (ram[a] !== exp_mem[a]) bad++;
    chk_cnt++;
    if (bad != 0) $display("FAIL %s_memory: got %0d differing bytes, required 0", name, bad);
    else pass_cnt++;
    chk_cnt++;
    if (exp_q.size() != 0) $display("FAIL %s_pending: got %0d writes missing, required 0", name, exp_q.size());
    else pass_cnt++;
    exp_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk_cnt++;
    if ({finish, wren, address, data} !== 18'h0)
      $display("FAIL reset_outputs: got finish=%b wren=%b addr=%0h data=%0h, required all 0",
               finish, wren, address, data);
    else pass_cnt++;
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_first_iteration();
    int fn, fc;
    fill_identity();
    model_ksa(24'h010203, 256);
    drive_run(24'h010203, 24'h010203, -1, -1, -1, -1, fn, fc);
    chk_cnt++;
    if (wr_n[0] !== 6 || wr_a[0] !== 8'h00 || wr_d[0] !== 8'h01)
      $display("FAIL first_write: got n=%0d addr=%0h data=%0h, required n=6 addr=0 data=1", wr_n[0], wr_a[0], wr_d[0]);
    else pass_cnt++;
    chk_cnt++;
    if (wr_n[1] !== 7 || wr_a[1] !== 8'h01 || wr_d[1] !== 8'h00)
      $display("FAIL second_write: got n=%0d addr=%0h data=%0h, required n=7 addr=1 data=0", wr_n[1], wr_a[1], wr_d[1]);
    else pass_cnt++;
    chk_cnt++;
    if (wren_first !== 2) $display("FAIL first_iter_wren: got %0d cycles, required 2", wren_first);
    else pass_cnt++;
    check_done("first_iter", fn, fc);
  endtask

  task automatic test_zero_key();
    int fn, fc;
    fill_identity();
    model_ksa(24'h000000, 256);
    drive_run(24'h000000, 24'h000000, -1, -1, -1, -1, fn, fc);
    chk_cnt++;
    if (snap2 !== 8'h03 || snap3 !== 8'h02)
      $display("FAIL zero_key_i2: got S2=%0h S3=%0h, required S2=3 S3=2", snap2, snap3);
    else pass_cnt++;
    check_done("zero_key", fn, fc);
  endtask

  task automatic test_key_249();
    int fn, fc;
    fill_identity();
    model_ksa(24'h000249, 256);
    drive_run(24'h000249, 24'h000249, -1, -1, -1, -1, fn, fc);
    check_done("key_249", fn, fc);
  endtask

  task automatic test_ignored_start();
    int fn, fc, extra;
    fill_identity();
    model_ksa(24'h5A17C3, 256);
    drive_run(24'h5A17C3, 24'h5A17C3, -1, 100, 2305, -1, fn, fc);
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (finish) extra++;
    end
    chk_cnt++;
    if (extra !== 0) $display("FAIL ignored_start_restart: got %0d extra finish, required 0", extra);
    else pass_cnt++;
    check_done("ignored_start", fn, fc);
  endtask

  task automatic test_abort();
    int fn, fc, fins, bad;
    fill_identity();
    model_ksa(24'h9E3701, 55);
    drive_run(24'h9E3701, 24'h9E3701, -1, -1, -1, 500, fn, fc);
    chk_cnt++;
    if (wren !== 1'b0 || finish !== 1'b0 || fc !== 0)
      $display("FAIL abort_outputs: got wren=%b finish=%b pulses=%0d, required 0 0 0", wren, finish, fc);
    else pass_cnt++;
    fins = 0;
    repeat (40) begin
      @(negedge clk);
      if (finish) fins++;
    end
    chk_cnt++;
    if (fins !== 0) $display("FAIL abort_finish: got %0d pulses, required 0", fins);
    else pass_cnt++;
    bad = 0;
    for (int a = 0; a < 256; a++) if (ram[a] !== exp_mem[a]) bad++;
    chk_cnt++;
    if (bad != 0 || exp_q.size() != 0)
      $display("FAIL abort_partial: got %0d bad bytes %0d missing writes, required 0 0", bad, exp_q.size());
    else pass_cnt++;
    exp_q.delete();
    model_ksa(24'h9E3701, 256);
    drive_run(24'h9E3701, 24'h9E3701, -1, -1, -1, -1, fn, fc);
    check_done("after_abort", fn, fc);
  endtask

  task automatic test_key_change();
    int fn, fc;
    fill_identity();
    model_ksa(24'h13579B, 256);
    drive_run(24'h13579B, 24'hFFEEDD, 3, -1, -1, -1, fn, fc);
    check_done("key_change", fn, fc);
  endtask

  task automatic test_back_to_back();
    int fn, fc;
    fill_identity();
    model_ksa(24'hA1B2C3, 256);
    drive_run(24'hA1B2C3, 24'hA1B2C3, -1, -1, -1, -1, fn, fc);
    check_done("b2b_first", fn, fc);
    model_ksa(24'h0F1E2D, 256);
    drive_run(24'h0F1E2D, 24'h0F1E2D, -1, -1, -1, -1, fn, fc);
    check_done("b2b_second", fn, fc);
  endtask

  initial begin
    fill_identity();
    test_reset();
    test_first_iteration();
    test_zero_key();
    test_key_249();
    test_ignored_start();
    test_abort();
    test_key_change();
    test_back_to_back();
    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
